// File: rtl/knn_nat_master_pkg.sv
// Shared definitions for the KNN native-bus read master: FSM state
// encoding and the bus wait timeout (used when KNN_MST_TIMEOUT_EN is set).
package knn_nat_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Maximum number of cycles a request may wait for m_ready.
  localparam logic [15:0] KNN_MST_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/knn_nat_master_fifo.sv
// knn_mst_fifo: small synchronous FIFO buffering fetched words for the
// KNN datapath. dout is driven from registered storage and reads 0 when empty.
module knn_mst_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/knn_nat_master.sv
// knn_nat_master: native-interface read master fetching len consecutive
// words from base_addr and streaming them out through a small FIFO.
// Optional macro KNN_MST_TIMEOUT_EN adds an error output and bus wait timeout.
module knn_nat_master
  import knn_nat_master_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready
`ifdef KNN_MST_TIMEOUT_EN
  ,
  output logic                error
`endif
);

  localparam int STRIDE = DATA_W / 8;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(STRIDE - 1));

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic             push;
  logic             pop;
  logic             flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   count_next;
  logic             has_slot;

  assign m_wdata = '0;
  assign m_wstrb = '0;

  assign push       = (state == REQ) & m_valid & m_ready;
  assign pop        = dout_valid & dout_ready;
  assign dout_valid = ~fifo_empty;

  // Occupancy after this edge; a request may only be raised if a slot will
  // still be free in the cycle it can first be answered.
  always_comb begin
    count_next = {1'b0, fifo_count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
    has_slot   = push ? (count_next < (CNT_W + 1)'(FIFO_DEPTH)) : (~fifo_full | pop);
  end

`ifdef KNN_MST_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_hit;

  // Request has been waiting its final allowed cycle without a response.
  always_comb begin
    timeout_hit = (state == REQ) & m_valid & ~m_ready &
                  (wait_cnt == KNN_MST_TIMEOUT - 16'd1);
  end
  assign flush = timeout_hit;
`else
  assign flush = 1'b0;
`endif

  knn_mst_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (m_rdata),
    .pop   (pop),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control FSM with registered bus request, address/remaining counters and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      rem     <= '0;
`ifdef KNN_MST_TIMEOUT_EN
      wait_cnt <= '0;
      error    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef KNN_MST_TIMEOUT_EN
            error    <= 1'b0;
            wait_cnt <= '0;
`endif
            if (len != '0) begin
              // FIFO is always empty in IDLE, so the first request can go out at once.
              state   <= REQ;
              m_addr  <= base_addr & ADDR_MASK;
              rem     <= len;
              m_valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (m_valid && m_ready) begin
            m_addr <= m_addr + ADDR_W'(STRIDE);
            rem    <= rem - LEN_W'(1);
`ifdef KNN_MST_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (rem == LEN_W'(1)) begin
              m_valid <= 1'b0;
              state   <= DRAIN;
            end else begin
              m_valid <= has_slot;
            end
          end else if (m_valid) begin
`ifdef KNN_MST_TIMEOUT_EN
            if (timeout_hit) begin
              m_valid  <= 1'b0;
              error    <= 1'b1;
              wait_cnt <= '0;
              state    <= DONE;
              done     <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
`endif
          end else begin
            m_valid <= has_slot;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_nat_master.sv
// Scoreboard bench for knn_nat_master: expected bus addresses and output
// words are queued at stimulus time and checked by a separate monitor.
module tb_knn_nat_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, m_valid, m_ready, dout_valid;
  logic        dout_ready = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata, dout;
  logic [3:0]  m_wstrb;
`ifdef KNN_MST_TIMEOUT_EN
  logic        error;
`endif

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int done_count = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  int   wait_cycles = 0;
  int   wait_ctr = 0;
  logic slave_en = 1'b1;
  logic force_ready = 1'b0;
  logic hold_check_en = 1'b1;

  always #5 clk = ~clk;

  knn_nat_master #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .LEN_W      (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .m_valid    (m_valid),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef KNN_MST_TIMEOUT_EN
    ,
    .error      (error)
`endif
  );

  // Slave model: memory word is address-derived; ready after wait_cycles waits.
  assign m_rdata = m_addr ^ 32'h5A5A_0000;
  assign m_ready = force_ready | (slave_en & m_valid & (wait_ctr == wait_cycles));

  always @(posedge clk) begin
    if (!m_valid || m_ready) wait_ctr <= 0;
    else                     wait_ctr <= wait_ctr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: bus handshakes, output pops, request stability and done pulses.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (prev_wait && !rst && hold_check_en) begin
      check("hold_m_valid", 32'(m_valid), 32'd1);
      check("hold_m_addr", m_addr, prev_addr);
    end
    if (m_valid && m_ready) begin
      hs_count++;
      if (exp_addr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_req: got addr 0x%08h expected no request", m_addr);
      end else begin
        check("m_addr", m_addr, exp_addr_q.pop_front());
      end
    end
    if (dout_valid && dout_ready) begin
      if (exp_data_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_dout: got 0x%08h expected no word", dout);
      end else begin
        check("dout", dout, exp_data_q.pop_front());
      end
    end
    if (done) done_count++;
    prev_wait = m_valid && !m_ready;
    prev_addr = m_addr;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
    base_addr = b;
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_fetch(input logic [31:0] b, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(4 * i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(a ^ 32'h5A5A_0000);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: got no done within %0d cycles expected done pulse", name, budget);
    end
    tick();
  endtask

  int h0, d0;

  initial begin
    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("wdata_zero", m_wdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 4-word fetch, single-cycle slave, no backpressure
    dout_ready = 1'b1;
    wait_cycles = 0;
    h0 = hs_count; d0 = done_count;
    expect_fetch(32'h100, 4);
    pulse_start(32'h100, 16'd4);
    check("first_req_latency", 32'(m_valid), 32'd1);
    wait_done(50, "fetch4_done");
    tick(2);
    check("fetch4_handshakes", 32'(hs_count - h0), 32'd4);
    check("fetch4_done_once", 32'(done_count - d0), 32'd1);
    check("fetch4_busy_after", 32'(busy), 32'd0);
    check("fetch4_words_left", 32'(exp_data_q.size()), 32'd0);

    // 3 wait cycles per word
    wait_cycles = 3;
    h0 = hs_count;
    expect_fetch(32'h200, 2);
    pulse_start(32'h200, 16'd2);
    wait_done(60, "wait3_done");
    tick(2);
    check("wait3_handshakes", 32'(hs_count - h0), 32'd2);
    wait_cycles = 0;

    // Backpressure: only two words fit before requests stop
    dout_ready = 1'b0;
    h0 = hs_count;
    expect_fetch(32'h300, 5);
    pulse_start(32'h300, 16'd5);
    tick(20);
    check("bp_handshakes", 32'(hs_count - h0), 32'd2);
    check("bp_m_valid", 32'(m_valid), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_head", dout, 32'h300 ^ 32'h5A5A_0000);
    dout_ready = 1'b1;
    wait_done(60, "bp_done");
    tick(2);
    check("bp_total_handshakes", 32'(hs_count - h0), 32'd5);
    check("bp_words_left", 32'(exp_data_q.size()), 32'd0);

    // len == 0: done on the cycle after start, no request
    h0 = hs_count;
    pulse_start(32'h700, 16'd0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("len0_done_drop", 32'(done), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_handshakes", 32'(hs_count - h0), 32'd0);

    // Address wrap
    h0 = hs_count;
    expect_fetch(32'hFFFF_FFFC, 2);
    pulse_start(32'hFFFF_FFFC, 16'd2);
    wait_done(30, "wrap_done");
    tick(2);
    check("wrap_handshakes", 32'(hs_count - h0), 32'd2);

    // Unaligned base is aligned down
    expect_fetch(32'h100, 1);
    pulse_start(32'h103, 16'd1);
    check("align_addr", m_addr, 32'h100);
    wait_done(30, "align_done");
    tick(2);

    // Reset after 2 of 6 words
    dout_ready = 1'b0;
    h0 = hs_count;
    exp_addr_q.push_back(32'h400);
    exp_addr_q.push_back(32'h404);
    pulse_start(32'h400, 16'd6);
    for (int k = 0; k < 20 && (hs_count - h0) < 2; k++) tick();
    tick(2);
    check("pre_rst_dout_valid", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dout", dout, 32'd0);
    tick();

    // New fetch; a second start while busy is ignored
    dout_ready = 1'b1;
    h0 = hs_count;
    expect_fetch(32'h500, 3);
    pulse_start(32'h500, 16'd3);
    pulse_start(32'h900, 16'd2);
    wait_done(40, "refetch_done");
    tick(4);
    check("refetch_handshakes", 32'(hs_count - h0), 32'd3);
    check("refetch_busy", 32'(busy), 32'd0);
    check("refetch_addr_left", 32'(exp_addr_q.size()), 32'd0);

    // m_ready while idle is ignored
    force_ready = 1'b1;
    tick(3);
    force_ready = 1'b0;
    check("idle_ready_busy", 32'(busy), 32'd0);
    check("idle_ready_dout_valid", 32'(dout_valid), 32'd0);

`ifdef KNN_MST_TIMEOUT_EN
    // Slave never responds: timeout ends the fetch with error
    slave_en = 1'b0;
    hold_check_en = 1'b0;
    check("pre_timeout_error", 32'(error), 32'd0);
    pulse_start(32'h600, 16'd1);
    wait_done(70000, "timeout_done");
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_m_valid", 32'(m_valid), 32'd0);
    tick(2);
    slave_en = 1'b1;
    hold_check_en = 1'b1;
    expect_fetch(32'h600, 1);
    pulse_start(32'h600, 16'd1);
    check("error_cleared", 32'(error), 32'd0);
    wait_done(30, "post_timeout_done");
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knn_nat_master.md
Name: knn_nat_master

Overview:
- Native-interface bus initiator: the master end of the cpu_nat valid/address/wdata/wstrb/rdata/ready protocol, which KNN peripherals implement as slaves.
- Fetches a block of LEN consecutive 32-bit words (training points) from memory starting at BASE_ADDR.
- Streams the words to the KNN datapath through a valid/ready output port with a 2-entry buffer.
- Sits between the system memory interconnect and knn_core data input; started and monitored by the KNN software register file.

Parameters:
- ADDR_W, 32, byte-address width of m_addr and base_addr
- DATA_W, 32, data word width; address stride is DATA_W/8
- LEN_W, 16, width of the word-count input
- FIFO_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse to begin a fetch
- base_addr  in  ADDR_W  byte start address; low log2(DATA_W/8) bits are ignored
- len  in  LEN_W  number of words to fetch
- busy  out  1  high from the accepted start until the done pulse
- done  out  1  one-cycle completion pulse
- m_valid  out  1  native bus request
- m_addr  out  ADDR_W  native bus address
- m_wdata  out  DATA_W  tied to 0
- m_wstrb  out  DATA_W/8  tied to 0 (reads only)
- m_rdata  in  DATA_W  read data, valid in the m_ready cycle
- m_ready  in  1  slave response
- dout  out  DATA_W  FIFO head word
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  consumer accepts dout

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values of registered outputs: busy=0, done=0, m_valid=0, m_addr=0, dout_valid=0. dout=0 while the FIFO is empty.
- FSM states: IDLE, REQ, DRAIN, DONE.
  - IDLE, on start with len!=0: latch addr=base_addr aligned and rem=len, go to REQ.
  - IDLE, on start with len==0: go straight to DONE.
  - start is ignored in any state other than IDLE.
  - REQ: m_valid=1 only when the FIFO has a free slot, counting a slot freed by a pop in the same cycle.
  - REQ, once m_valid is asserted: m_valid and m_addr stay stable until m_ready (native protocol rule).
  - REQ, on m_valid&m_ready: push m_rdata; addr += DATA_W/8; rem -= 1. If rem becomes 0, m_valid drops on the next edge and the FSM goes to DRAIN.
  - DRAIN: wait for the FIFO to empty, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- Latency: the first request is issued on the cycle after start; minimum 1 cycle per word when the slave answers combinationally and dout_ready=1.
- The address counter wraps modulo 2^ADDR_W without error.
- FIFO rules:
  - Simultaneous push and pop when full is legal; the count is unchanged.
  - No overflow can occur, because the request gating ensures a slot exists.
  - dout/dout_valid come from registered FIFO storage (no combinational path from m_rdata).
- Reset mid-operation: the FSM returns to IDLE, the FIFO is flushed, and m_valid drops after the edge. An outstanding bus request is abandoned; this is acceptable only on system reset.
- m_ready while m_valid=0 is ignored.

Optional Feature:
- Macro: KNN_MST_TIMEOUT_EN
- Defined: adds output error (1 bit, reset 0) and a 16-bit wait counter.
  - If m_valid stays high for 65535 cycles without m_ready: drop m_valid, flush the FIFO, set error=1, and go to DONE.
  - error clears on the next accepted start.
- Undefined: no error port; the master waits indefinitely.

Decomposition:
- Shared header iob_knn_mst.vh:
  - FSM state encodings (2-bit IDLE=0, REQ=1, DRAIN=2, DONE=3)
  - KNN_MST_TIMEOUT value
  - address stride macro
- One sub-module, knn_mst_fifo: synchronous FIFO_DEPTH-entry buffer with push, pop, full, empty and a count output.
- The FSM, counters and bus logic live in the top module.

Test Plan:
- Fetch of 4 words, slave answers in 1 cycle, dout_ready=1:
  - base_addr=0x100, len=4 -> m_addr sequence 0x100, 0x104, 0x108, 0x10C.
  - dout sequence equals memory words.
  - done pulses exactly once; busy is low afterwards.
- Slave with a 3-cycle wait per word, len=2 -> m_valid and m_addr are held stable through every wait cycle; exactly 2 handshakes occur.
- Backpressure:
  - dout_ready=0, len=5 -> at most 2 handshakes occur and then m_valid stays 0.
  - Raising dout_ready -> the remaining 3 words are delivered in order; no loss or duplication.
- Boundary starts:
  - len=0 -> done pulses on the second cycle with no m_valid.
  - base_addr=0xFFFFFFFC, len=2 -> addresses 0xFFFFFFFC then 0x00000000.
  - base_addr=0x103 -> first address is 0x100.
- rst asserted mid-fetch (after 2 of 6 words):
  - next cycle: m_valid=0, dout_valid=0, busy=0.
  - A new start fetches correctly; a start pulse during busy is ignored.
- (KNN_MST_TIMEOUT_EN) Slave never asserts m_ready -> after 65535 cycles error=1, done pulses, m_valid=0.
